if_stage: RTL and testbench

Instruction-fetch stage for the pipelined Enka ARM core. Holds the fetch PC, issues 32-bit instruction reads to the i$ over a request/response handshake, and buffers returned words with their PCs in a small FIFO. Presents them to decode under valid/ready. A redirect from the branch-resolution stage restarts fetch at a new PC and discards wrong-path instructions, both buffered and in flight.

---
 rtl/if_stage.sv | 102 ++++++++++
 tb/tb_if_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch: one i$ read per credit, in-order responses buffered with their PCs in a DEPTH-entry FIFO.
// Latency accept->id_valid is k+1 cycles; decode backpressure holds credits, redirect drops everything older.
module if_stage #(
    parameter logic [63:0] PC_INIT = 64'h0,
    parameter int          DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [63:0] id_pc
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [63:0]   r_fetch_pc;
    logic [63:0]   r_fifo_pc   [DEPTH];
    logic [31:0]   r_fifo_inst [DEPTH];
    logic [63:0]   r_tag       [DEPTH];
    logic [AW-1:0] r_fifo_rd, r_fifo_wr, r_tag_rd, r_tag_wr;
    logic [CW-1:0] r_count, r_live, r_drop;

    logic [CW+1:0] w_used;
    logic [CW-1:0] w_pend;
    logic [CW-1:0] w_drop_redir;
    logic          w_acc, w_rsp, w_keep, w_pop;

    // Every term is registered, so a freed slot only becomes a credit next cycle.
    assign w_used   = (CW+2)'(r_count) + (CW+2)'(r_live) + (CW+2)'(r_drop);
    assign imem_req = !rst && !redirect_valid && (w_used < (CW+2)'(DEPTH));
    assign imem_addr = r_fetch_pc;

    assign w_acc  = imem_req && imem_ready;
    assign w_rsp  = imem_rvalid && !rst;
    assign w_keep = w_rsp && !redirect_valid && (r_drop == '0) && (r_live != '0);

    assign id_valid = (r_count != '0) && !redirect_valid;
    assign w_pop    = id_valid && id_ready;
    assign id_inst  = (r_count != '0) ? r_fifo_inst[r_fifo_rd] : '0;
    assign id_pc    = (r_count != '0) ? r_fifo_pc[r_fifo_rd]   : '0;

    // The response landing in the redirect cycle retires one pending request.
    assign w_pend       = r_drop + r_live;
    assign w_drop_redir = (w_rsp && (w_pend != '0)) ? w_pend - CW'(1) : w_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= PC_INIT;
            r_fifo_rd  <= '0;
            r_fifo_wr  <= '0;
            r_tag_rd   <= '0;
            r_tag_wr   <= '0;
            r_count    <= '0;
            r_live     <= '0;
            r_drop     <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc & ~64'h3;
            r_fifo_rd  <= '0;
            r_fifo_wr  <= '0;
            r_tag_rd   <= '0;
            r_tag_wr   <= '0;
            r_count    <= '0;
            r_live     <= '0;
            r_drop     <= w_drop_redir;
        end else begin
            if (w_acc) begin
                r_tag[r_tag_wr] <= r_fetch_pc;
                r_tag_wr        <= r_tag_wr + AW'(1);
                r_fetch_pc      <= r_fetch_pc + 64'd4;
            end
            if (w_keep) begin
                r_fifo_pc[r_fifo_wr]   <= r_tag[r_tag_rd];
                r_fifo_inst[r_fifo_wr] <= imem_rdata;
                r_fifo_wr              <= r_fifo_wr + AW'(1);
                r_tag_rd               <= r_tag_rd + AW'(1);
            end
            if (w_pop) begin
                r_fifo_rd <= r_fifo_rd + AW'(1);
            end
            r_count <= r_count + CW'(w_keep) - CW'(w_pop);
            r_live  <= r_live + CW'(w_acc) - CW'(w_keep);
            if (w_rsp && (r_drop != '0)) begin
                r_drop <= r_drop - CW'(1);
            end
        end
    end

    // A response with nothing outstanding is an i$ protocol violation and is ignored.
    always_ff @(posedge clk) begin
        if (!rst && imem_rvalid) begin
            assert ((r_live != '0) || (r_drop != '0));
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: scripted i$ responder with per-request latency, PC-stream reference model.
module tb_if_stage;
    localparam logic [63:0] PC_INIT = 64'h0;
    localparam int          DEPTH   = 4;

    logic        clk = 1'b0;
    logic        rst, imem_req, imem_ready, imem_rvalid, redirect_valid;
    logic        id_valid, id_ready;
    logic [63:0] imem_addr, redirect_pc, id_pc;
    logic [31:0] imem_rdata, id_inst;

    if_stage #(.PC_INIT(PC_INIT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } rq_t;

    rq_t         q[$];
    int          checks = 0, failures = 0;
    int          cyc = 0, lat = 1, n_acc = 0, n_pop = 0;
    logic [63:0] exp_pc, exp_fetch;
    logic        s_req, s_vld;
    logic [63:0] s_addr, s_pc;
    logic [31:0] s_inst;

    function automatic logic [31:0] mem(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sample at negedge, advance one clock, then drive the i$ response for the new cycle.
    task automatic cycle();
        @(negedge clk);
        s_req = imem_req; s_addr = imem_addr; s_vld = id_valid; s_pc = id_pc; s_inst = id_inst;
        if (rst) begin
            q.delete();
            exp_pc = PC_INIT; exp_fetch = PC_INIT; n_acc = 0; n_pop = 0;
        end else if (redirect_valid) begin
            chk("redir_no_req", 64'(imem_req), 64'd0);
            chk("redir_no_vld", 64'(id_valid), 64'd0);
            exp_pc    = redirect_pc & ~64'h3;
            exp_fetch = redirect_pc & ~64'h3;
        end else begin
            if (imem_req && imem_ready) begin
                chk("fetch_addr", imem_addr, exp_fetch);
                q.push_back('{addr: imem_addr, due: cyc + lat});
                exp_fetch = exp_fetch + 64'd4;
                n_acc++;
            end
            if (id_valid && id_ready) begin
                chk("id_pc", id_pc, exp_pc);
                chk("id_inst", 64'(id_inst), 64'(mem(exp_pc)));
                exp_pc = exp_pc + 64'd4;
                n_pop++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!rst && q.size() > 0 && q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem(q[0].addr);
            void'(q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic wait_vld(input string tag, input logic [63:0] exp);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!s_vld && n < 40);
        chk({tag, "_vld"}, 64'(s_vld), 64'd1);
        chk({tag, "_pc"}, s_pc, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_ready = 1'b1; id_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;

        // Reset state.
        repeat (3) cycle();
        chk("rst_req", 64'(s_req), 64'd0);
        chk("rst_vld", 64'(s_vld), 64'd0);
        chk("rst_pc", s_pc, 64'd0);
        chk("rst_inst", 64'(s_inst), 64'd0);

        // Zero-wait i$, k=1: first request immediately, one instruction per cycle from cycle 3.
        rst = 1'b0;
        cycle();
        chk("first_req", 64'(s_req), 64'd1);
        chk("first_addr", s_addr, PC_INIT);
        cycle();
        chk("c2_vld", 64'(s_vld), 64'd0);
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("stream_vld", 64'(s_vld), 64'd1);
        end

        // Decode backpressure: credits run out at DEPTH buffered+outstanding.
        id_ready = 1'b0;
        repeat (8) cycle();
        chk("bp_req", 64'(s_req), 64'd0);
        chk("bp_outstanding", 64'(n_acc - n_pop), 64'(DEPTH));
        id_ready = 1'b1;
        repeat (10) cycle();
        chk("bp_resume_vld", 64'(s_vld), 64'd1);

        // i$ stall at 0x10; reset also overrides a concurrent redirect.
        redirect_valid = 1'b1; redirect_pc = 64'h7770;
        do_reset();
        repeat (4) cycle();
        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_addr", s_addr, 64'h10);
            chk("stall_req", 64'(s_req), 64'd1);
        end
        imem_ready = 1'b1;
        cycle();
        chk("stall_acc_addr", s_addr, 64'h10);
        cycle();
        chk("stall_next_addr", s_addr, 64'h14);

        // Redirect with two live requests, k=3.
        do_reset();
        lat = 3;
        repeat (2) cycle();
        redirect_valid = 1'b1; redirect_pc = 64'h1000;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        chk("rd1_req", 64'(s_req), 64'd1);
        chk("rd1_addr", s_addr, 64'h1000);
        chk("rd1_vld", 64'(s_vld), 64'd0);
        wait_vld("rd1_first", 64'h1000);

        // Redirect coincident with a response while credits are exhausted.
        do_reset();
        lat = 2; id_ready = 1'b0;
        repeat (4) cycle();
        for (int i = 0; i < 20 && !imem_rvalid; i++) cycle();
        redirect_valid = 1'b1; redirect_pc = 64'h4440;
        cycle();
        redirect_valid = 1'b0; id_ready = 1'b1;
        cycle();
        chk("fl_vld", 64'(s_vld), 64'd0);
        chk("fl_req", 64'(s_req), 64'd1);
        chk("fl_addr", s_addr, 64'h4440);
        wait_vld("fl_first", 64'h4440);

        // Unaligned redirect, then a second redirect while old responses are still being dropped.
        do_reset();
        lat = 5;
        repeat (3) cycle();
        redirect_valid = 1'b1; redirect_pc = 64'h2003;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        chk("rd2_addr0", s_addr, 64'h2000);
        cycle();
        chk("rd2_addr1", s_addr, 64'h2004);
        redirect_valid = 1'b1; redirect_pc = 64'h3000;
        cycle();
        redirect_valid = 1'b0;
        lat = 1;
        wait_vld("rd3_first", 64'h3000);

        // Randomized traffic against the PC-stream model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            imem_ready     = ($urandom_range(0, 3) != 0);
            id_ready       = ($urandom_range(0, 9) < 7);
            lat            = $urandom_range(1, 4);
            redirect_valid = ($urandom_range(0, 39) == 0);
            redirect_pc    = {$urandom, $urandom};
            cycle();
        end
        redirect_valid = 1'b0; imem_ready = 1'b1; id_ready = 1'b1; lat = 1;
        repeat (20) cycle();
        chk("drain_vld", 64'(s_vld), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
